// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared constants and types for the register-file write-back controller.
package regfile_wb_ctrl_pkg;

  localparam int DEF_XLEN       = 32;
  localparam int DEF_FIFO_DEPTH = 2;
  localparam int REG_ADDR_W     = 5;
  localparam int NUM_REGS       = 32;

  // Source feeding the write stage in a given cycle
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_FIFO = 2'd2
  } wb_src_e;

  // x0 is hardwired to zero: never written, never busy, never forwarded
  function automatic logic rd_nonzero(input logic [REG_ADDR_W-1:0] rd);
    return rd != '0;
  endfunction

endpackage

// File: rtl/regfile_wb_ctrl_fifo.sv
// Small synchronous FIFO buffering long-latency {rd,data} results.
module regfile_wb_ctrl_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Next-state for pointers, occupancy and storage; pointers wrap since DEPTH is a power of 2
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers; reset empties the FIFO
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are only visible when count is non-zero
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-port arbiter: ALU results first, buffered long results otherwise,
// with a busy scoreboard for long-op destinations and write-stage forwarding to both read ports.
module regfile_wb_ctrl
  import regfile_wb_ctrl_pkg::*;
#(
  parameter int XLEN       = DEF_XLEN,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]       lsu_data,
  input  logic                  iss_valid,
  input  logic [REG_ADDR_W-1:0] iss_rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic [XLEN-1:0]       rf_q1,
  input  logic [XLEN-1:0]       rf_q2,
  output logic [XLEN-1:0]       fwd_q1,
  output logic [XLEN-1:0]       fwd_q2,
  output logic                  busy_rs1,
  output logic                  busy_rs2,
  output logic                  busy_rd,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  wb_wen,
  output logic [XLEN-1:0]       wb_data
);

  localparam int ENTRY_W = REG_ADDR_W + XLEN;

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0]    fifo_head;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [XLEN-1:0]       head_data;
  wb_src_e               wb_src;

  logic                  wb_wen_q, wb_wen_d;
  logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]       wb_data_q, wb_data_d;
  logic [NUM_REGS-1:0]   sb_q, sb_d;

  // Ready depends only on registered occupancy, so a same-cycle pop does not open a slot
  assign lsu_ready = !fifo_full;
  assign fifo_push = lsu_valid && !fifo_full;
  assign fifo_pop  = (wb_src == SRC_FIFO);
  assign {head_rd, head_data} = fifo_head;

  regfile_wb_ctrl_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_push),
    .pop  (fifo_pop),
    .din  ({lsu_rd, lsu_data}),
    .head (fifo_head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // Write-port arbitration: ALU has strict priority, the FIFO head waits
  always_comb begin
    wb_src = SRC_NONE;
    if (alu_valid) begin
      wb_src = SRC_ALU;
    end else if (!fifo_empty) begin
      wb_src = SRC_FIFO;
    end
  end

  // Write-stage next values; an x0 destination still consumes its slot but never writes
  always_comb begin
    wb_wen_d  = 1'b0;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    case (wb_src)
      SRC_ALU: begin
        wb_wen_d  = rd_nonzero(alu_rd);
        wb_rd_d   = alu_rd;
        wb_data_d = alu_data;
      end
      SRC_FIFO: begin
        wb_wen_d  = rd_nonzero(head_rd);
        wb_rd_d   = head_rd;
        wb_data_d = head_data;
      end
      default: ;
    endcase
  end

  // Scoreboard: clear on pop of a long result, issue set applied last so it wins
  always_comb begin
    sb_d = sb_q;
    if (fifo_pop) begin
      sb_d[head_rd] = 1'b0;
    end
    if (iss_valid) begin
      sb_d[iss_rd] = 1'b1;
    end
    sb_d[0] = 1'b0;
  end

  // Write-stage and scoreboard registers; reset drops any in-flight write
  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_wen_q  <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      sb_q      <= '0;
    end else begin
      wb_wen_q  <= wb_wen_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      sb_q      <= sb_d;
    end
  end

  assign wb_wen  = wb_wen_q;
  assign wb_rd   = wb_rd_q;
  assign wb_data = wb_data_q;

  // Forward the pending register-file write to both read ports
  assign fwd_q1 = (wb_wen_q && (wb_rd_q == rs1) && rd_nonzero(rs1)) ? wb_data_q : rf_q1;
  assign fwd_q2 = (wb_wen_q && (wb_rd_q == rs2) && rd_nonzero(rs2)) ? wb_data_q : rf_q2;

  assign busy_rs1 = sb_q[rs1];
  assign busy_rs2 = sb_q[rs2];
  assign busy_rd  = sb_q[iss_rd];

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: a monitor pops expected writes from a queue.
module tb_regfile_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, lsu_valid, iss_valid;
  logic [4:0]  alu_rd, lsu_rd, iss_rd, rs1, rs2;
  logic [31:0] alu_data, lsu_data, rf_q1, rf_q2;
  logic        lsu_ready, busy_rs1, busy_rs2, busy_rd, wb_wen;
  logic [31:0] fwd_q1, fwd_q2, wb_data;
  logic [4:0]  wb_rd;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;

  regfile_wb_ctrl dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .rs1(rs1), .rs2(rs2), .rf_q1(rf_q1), .rf_q2(rf_q2),
    .fwd_q1(fwd_q1), .fwd_q2(fwd_q2),
    .busy_rs1(busy_rs1), .busy_rs2(busy_rs2), .busy_rd(busy_rd),
    .wb_rd(wb_rd), .wb_wen(wb_wen), .wb_data(wb_data)
  );

  // Every visible register-file write must match the oldest expected write
  always @(negedge clk) begin
    if (mon_en && wb_wen !== 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got wen=%b rd=%0d data=%h, required no write", wb_wen, wb_rd, wb_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (wb_rd !== e.rd || wb_data !== e.data) begin
          errors++;
          $display("FAIL write_order: got rd=%0d data=%h, required rd=%0d data=%h", wb_rd, wb_data, e.rd, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [4:0] rd, input logic [31:0] data);
    exp_t e;
    e.rd = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 30 && exp_q.size() > 0; i++) cyc();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d writes outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h0BAD_F00D;
    iss_valid = 1'b1; iss_rd = 5'd4;
    lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = '0;
    rs1 = 5'd4; rs2 = 5'd4; rf_q1 = '0; rf_q2 = '0;
    cyc();
    cyc();
    checks++; if (wb_wen !== 1'b0) begin errors++; $display("FAIL reset_wen: got %b, required 0", wb_wen); end
    checks++; if (wb_rd !== 5'd0) begin errors++; $display("FAIL reset_rd: got %0d, required 0", wb_rd); end
    checks++; if (wb_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %h, required 0", wb_data); end
    checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, required 1", lsu_ready); end
    checks++; if (busy_rs1 !== 1'b0 || busy_rs2 !== 1'b0 || busy_rd !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b%b%b, required 000", busy_rs1, busy_rs2, busy_rd);
    end
    rst = 1'b1; alu_valid = 1'b0; iss_valid = 1'b0;
    mon_en = 1'b1;
    cyc();
  endtask

  task automatic test_alu_write();
    logic [4:0]  rds [3];
    logic [31:0] d;
    rds = '{5'd1, 5'd2, 5'd31};
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
    push_exp(5'd5, 32'hDEAD_BEEF);
    cyc();
    alu_valid = 1'b0;
    checks++; if (wb_wen !== 1'b1 || wb_rd !== 5'd5) begin
      errors++; $display("FAIL alu_latency: got wen=%b rd=%0d, required wen=1 rd=5", wb_wen, wb_rd);
    end
    rs1 = 5'd5; rf_q1 = 32'h1111_1111; rs2 = 5'd5; rf_q2 = 32'h2222_2222;
    #1;
    checks++; if (fwd_q1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL fwd_q1_hit: got %h, required deadbeef", fwd_q1); end
    checks++; if (fwd_q2 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL fwd_q2_hit: got %h, required deadbeef", fwd_q2); end
    rs1 = 5'd6;
    #1;
    checks++; if (fwd_q1 !== 32'h1111_1111) begin errors++; $display("FAIL fwd_q1_miss: got %h, required 11111111", fwd_q1); end
    for (int i = 0; i < 3; i++) begin
      d = $urandom;
      alu_valid = 1'b1; alu_rd = rds[i]; alu_data = d;
      push_exp(rds[i], d);
      cyc();
    end
    alu_valid = 1'b0;
    rs1 = 5'd31;
    #1;
    checks++; if (fwd_q1 !== d) begin errors++; $display("FAIL fwd_b2b: got %h, required %h", fwd_q1, d); end
    wait_drain();
  endtask

  task automatic test_lsu_path();
    iss_valid = 1'b1; iss_rd = 5'd7;
    cyc();
    iss_valid = 1'b0; rs1 = 5'd7; rs2 = 5'd7;
    #1;
    checks++; if (busy_rd !== 1'b1 || busy_rs1 !== 1'b1 || busy_rs2 !== 1'b1) begin
      errors++; $display("FAIL busy_after_issue: got %b%b%b, required 111", busy_rs1, busy_rs2, busy_rd);
    end
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h0000_1234;
    #1;
    checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL lsu_ready_idle: got %b, required 1", lsu_ready); end
    push_exp(5'd7, 32'h0000_1234);
    cyc();
    lsu_valid = 1'b0;
    checks++; if (wb_wen !== 1'b0 || busy_rd !== 1'b1) begin
      errors++; $display("FAIL lsu_push_plus1: got wen=%b busy=%b, required wen=0 busy=1", wb_wen, busy_rd);
    end
    cyc();
    checks++; if (wb_wen !== 1'b1 || wb_rd !== 5'd7 || wb_data !== 32'h0000_1234) begin
      errors++; $display("FAIL lsu_push_plus2: got wen=%b rd=%0d data=%h, required 1 7 00001234", wb_wen, wb_rd, wb_data);
    end
    checks++; if (busy_rd !== 1'b0) begin errors++; $display("FAIL busy_clear: got %b, required 0", busy_rd); end
    // Re-issue to the same rd in the pop cycle: the set must win
    iss_valid = 1'b1; iss_rd = 5'd9;
    cyc();
    iss_valid = 1'b0;
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'hA5A5_A5A5;
    push_exp(5'd9, 32'hA5A5_A5A5);
    cyc();
    lsu_valid = 1'b0;
    iss_valid = 1'b1;
    cyc();
    iss_valid = 1'b0;
    checks++; if (wb_wen !== 1'b1 || wb_rd !== 5'd9 || busy_rd !== 1'b1) begin
      errors++; $display("FAIL set_wins: got wen=%b rd=%0d busy=%b, required 1 9 1", wb_wen, wb_rd, busy_rd);
    end
    lsu_valid = 1'b1; lsu_data = 32'h5A5A_5A5A;
    push_exp(5'd9, 32'h5A5A_5A5A);
    cyc();
    lsu_valid = 1'b0;
    cyc();
    checks++; if (busy_rd !== 1'b0) begin errors++; $display("FAIL busy_clear2: got %b, required 0", busy_rd); end
    wait_drain();
  endtask

  task automatic test_contention();
    logic [4:0]  lrd [3];
    logic [31:0] ldat [3];
    exp_t        pend[$];
    exp_t        e;
    int          idx = 0;
    logic [31:0] d;
    lrd = '{5'd20, 5'd21, 5'd22};
    ldat = '{32'hC0DE_0020, 32'hC0DE_0021, 32'hC0DE_0022};
    for (int c = 0; c < 4; c++) begin
      d = $urandom;
      alu_valid = 1'b1; alu_rd = 5'(10 + c); alu_data = d;
      push_exp(5'(10 + c), d);
      lsu_valid = (idx < 3);
      if (idx < 3) begin lsu_rd = lrd[idx]; lsu_data = ldat[idx]; end
      #1;
      checks++; if (lsu_ready !== (c < 2)) begin
        errors++; $display("FAIL contention_ready c=%0d: got %b, required %b", c, lsu_ready, (c < 2));
      end
      if (lsu_valid && lsu_ready) begin
        e.rd = lrd[idx]; e.data = ldat[idx];
        pend.push_back(e);
        idx++;
      end
      cyc();
    end
    alu_valid = 1'b0;
    while (pend.size() > 0) exp_q.push_back(pend.pop_front());
    for (int t = 0; t < 20 && idx < 3; t++) begin
      lsu_valid = 1'b1; lsu_rd = lrd[idx]; lsu_data = ldat[idx];
      #1;
      if (lsu_ready) begin
        push_exp(lrd[idx], ldat[idx]);
        idx++;
      end
      cyc();
    end
    lsu_valid = 1'b0;
    checks++; if (idx != 3) begin errors++; $display("FAIL contention_accept: got %0d accepted, required 3", idx); end
    wait_drain();
  endtask

  task automatic test_x0();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h0000_0077;
    cyc();
    lsu_data = 32'h0000_0078;
    cyc();
    lsu_valid = 1'b0;
    checks++; if (lsu_ready !== 1'b0) begin errors++; $display("FAIL x0_full: got ready=%b, required 0", lsu_ready); end
    checks++; if (wb_wen !== 1'b0) begin errors++; $display("FAIL x0_alu_wen: got %b, required 0", wb_wen); end
    rs1 = 5'd0; rf_q1 = 32'h0000_CAFE;
    #1;
    checks++; if (fwd_q1 !== 32'h0000_CAFE) begin errors++; $display("FAIL x0_fwd: got %h, required 0000cafe", fwd_q1); end
    alu_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      checks++; if (wb_wen !== 1'b0) begin errors++; $display("FAIL x0_lsu_wen: got %b, required 0", wb_wen); end
    end
    // A fresh long result lands at push+2 only if the x0 entries have drained
    lsu_valid = 1'b1; lsu_rd = 5'd8; lsu_data = 32'h0000_0088;
    push_exp(5'd8, 32'h0000_0088);
    cyc();
    lsu_valid = 1'b0;
    cyc();
    checks++; if (wb_wen !== 1'b1 || wb_rd !== 5'd8) begin
      errors++; $display("FAIL x0_drain: got wen=%b rd=%0d, required wen=1 rd=8", wb_wen, wb_rd);
    end
    wait_drain();
  endtask

  task automatic test_mid_reset();
    iss_valid = 1'b1; iss_rd = 5'd15;
    cyc();
    iss_rd = 5'd16;
    cyc();
    iss_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd14; alu_data = 32'h1414_0001;
    push_exp(5'd14, 32'h1414_0001);
    lsu_valid = 1'b1; lsu_rd = 5'd15; lsu_data = 32'h1515_1515;
    cyc();
    alu_data = 32'h1414_0002;
    push_exp(5'd14, 32'h1414_0002);
    lsu_rd = 5'd16; lsu_data = 32'h1616_1616;
    cyc();
    alu_valid = 1'b0; lsu_valid = 1'b0;
    iss_rd = 5'd15;
    #1;
    checks++; if (lsu_ready !== 1'b0 || busy_rd !== 1'b1) begin
      errors++; $display("FAIL pre_reset_state: got ready=%b busy=%b, required 0 1", lsu_ready, busy_rd);
    end
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    rs1 = 5'd16;
    #1;
    checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready: got %b, required 1", lsu_ready); end
    checks++; if (busy_rd !== 1'b0 || busy_rs1 !== 1'b0) begin
      errors++; $display("FAIL mid_reset_busy: got rd=%b rs1=%b, required 0 0", busy_rd, busy_rs1);
    end
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++; if (wb_wen !== 1'b0) begin errors++; $display("FAIL mid_reset_wen cyc=%0d: got %b, required 0", i, wb_wen); end
    end
    checks++; if (exp_q.size() != 0) begin
      errors++; $display("FAIL mid_reset_missing: got %0d writes outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_lsu_path();
    test_contention();
    test_x0();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
